// File: rtl/aes256_inv_key_schedule.sv
// Reverse AES-256 key expansion: starts from {K13,K14} and streams the round
// keys K14..K0 over a valid/ready handshake, one back-step per accepted key.
module aes256_inv_key_schedule #(
  parameter logic [7:0] RC_INIT = 8'h40
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         done,
  output logic [31:0]  sbox_in,
  input  logic [31:0]  sbox_out
);

  // state   | meaning
  // IDLE    | waiting for start
  // EMIT_HI | presenting K14 from the low half of the window
  // EMIT_LO | presenting K[rk_idx] from the high half; back-step on accept
  typedef enum logic [1:0] {IDLE, EMIT_HI, EMIT_LO} state_t;

  state_t         state;
  logic [255:0]   win;
  logic [7:0]     rc;
  logic           handshake;
  logic           rcon_step;
  logic [31:0]    w_j3;
  logic [31:0]    t_word;
  logic [31:0]    w_m1, w_m2, w_m3, w_m4;
  logic [255:0]   win_prev;

  assign handshake = rk_valid && rk_ready;
  assign rk_out    = (state == EMIT_HI) ? win[127:0] : win[255:128];

  // Odd index means the word being recovered sits on a multiple of 8 in the
  // forward schedule, so it carried RotWord and Rcon.
  assign rcon_step = rk_idx[0];
  assign w_j3      = win[159:128];
  assign sbox_in   = rcon_step ? {w_j3[23:0], w_j3[31:24]} : w_j3;
  assign t_word    = rcon_step ? (sbox_out ^ {rc, 24'h0}) : sbox_out;

  assign w_m1 = win[31:0]   ^ win[63:32];
  assign w_m2 = win[63:32]  ^ win[95:64];
  assign w_m3 = win[95:64]  ^ win[127:96];
  assign w_m4 = win[127:96] ^ t_word;
  assign win_prev = {w_m4, w_m3, w_m2, w_m1, win[255:128]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      win      <= '0;
      rc       <= '0;
      rk_idx   <= '0;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            win      <= key_in;
            rc       <= RC_INIT;
            rk_idx   <= 4'd14;
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= EMIT_HI;
          end
        end
        EMIT_HI: begin
          if (handshake) begin
            rk_idx <= 4'd13;
            state  <= EMIT_LO;
          end
        end
        EMIT_LO: begin
          if (handshake) begin
            if (rk_idx == 4'd0) begin
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
              win    <= win_prev;
              rk_idx <= rk_idx - 4'd1;
              if (rcon_step) rc <= rc >> 1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes256_inv_key_schedule.sv
// Bench for the reverse AES-256 key schedule: a forward FIPS-197 expansion
// with a field-arithmetic S-box supplies both the DUT inputs and the expected keys.
module tb_aes256_inv_key_schedule;

  logic         clk;
  logic         reset;
  logic         start;
  logic [255:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         done;
  logic [31:0]  sbox_in;
  logic [31:0]  sbox_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]  mw [0:59];
  logic [127:0] got_k [0:14];

  localparam logic [255:0] C3_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  aes256_inv_key_schedule #(.RC_INIT(8'h40)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_out   (rk_out),
    .rk_idx   (rk_idx),
    .done     (done),
    .sbox_in  (sbox_in),
    .sbox_out (sbox_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse (x^254) then the affine map.
  function automatic logic [7:0] sbox_byte(input logic [7:0] x);
    logic [7:0] r, base, e;
    r    = 8'h01;
    base = x;
    e    = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, base);
      base = gmul(base, base);
    end
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_byte(w[31:24]), sbox_byte(w[23:16]), sbox_byte(w[15:8]), sbox_byte(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  assign sbox_out = sub_word(sbox_in);

  task automatic expand_key(input logic [255:0] key);
    logic [31:0] temp;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 8; i++) mw[i] = key[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      temp = mw[i-1];
      if (i % 8 == 0) begin
        temp = sub_word(rot_word(temp)) ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end else if (i % 8 == 4) begin
        temp = sub_word(temp);
      end
      mw[i] = mw[i-8] ^ temp;
    end
  endtask

  function automatic logic [127:0] model_rk(input int n);
    return {mw[4*n], mw[4*n+1], mw[4*n+2], mw[4*n+3]};
  endfunction

  function automatic logic [7:0] model_rc(input int idx);
    if (idx == 0) return 8'h00;
    if (idx % 2 == 1) return 8'h01 << ((idx - 1) / 2);
    return 8'h01 << (idx / 2 - 1);
  endfunction

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full (or aborted) stream. started=1 means the start for this key was
  // already accepted at the last edge (back-to-back restart).
  task automatic run_stream(input logic [255:0] key, input int ready_pct, input bit probe,
                            input int poke_idx, input int abort_idx, input bit started,
                            input bit restart, input logic [255:0] next_key);
    int  exp_idx, cyc;
    bit  held, finished, early_done, poked;
    logic [127:0] held_out;
    logic [3:0]   held_idx;
    logic [31:0]  w3;
    expand_key(key);
    if (!started) begin
      start  = 1'b1;
      key_in = {mw[52], mw[53], mw[54], mw[55], mw[56], mw[57], mw[58], mw[59]};
      step();
      start  = 1'b0;
    end
    cyc = 1;
    chk("k14_valid_next_cycle", rk_valid, 1'b1);
    chk("busy_after_start", busy, 1'b1);
    exp_idx = 14; held = 0; finished = 0; early_done = 0; poked = 0;
    while (!finished && cyc < 400) begin
      if (held) begin
        chk("stall_rk_out", rk_out, held_out);
        chk("stall_rk_idx", rk_idx, held_idx);
      end
      if (done) early_done = 1;
      start = 1'b0;
      if (abort_idx >= 0 && rk_valid && rk_idx == abort_idx[3:0]) begin
        reset = 1'b1;
        step();
        chk("abort_rk_valid", rk_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        reset = 1'b0;
        step();
        chk("abort_no_done_after", done, 1'b0);
        return;
      end
      if (poke_idx >= 0 && !poked && rk_valid && rk_idx == poke_idx[3:0]) begin
        start  = 1'b1;
        key_in = rand_key();
        poked  = 1;
      end
      rk_ready = ($urandom_range(99) < ready_pct);
      if (rk_valid && rk_ready) begin
        chk("rk_idx_order", rk_idx, exp_idx[3:0]);
        chk("rk_out_key", rk_out, model_rk(exp_idx));
        got_k[exp_idx] = rk_out;
        if (probe && exp_idx <= 13) begin
          chk("rc_probe", dut.rc, model_rc(exp_idx));
          if (exp_idx >= 1) begin
            w3 = mw[4*exp_idx + 3];
            chk("sbox_in_probe", sbox_in, (exp_idx % 2 == 1) ? rot_word(w3) : w3);
          end
        end
        if (exp_idx == 0) finished = 1;
        else exp_idx--;
      end
      held     = rk_valid && !rk_ready;
      held_out = rk_out;
      held_idx = rk_idx;
      step();
      cyc++;
    end
    start = 1'b0;
    chk("stream_complete", finished, 1'b1);
    chk("no_early_done", early_done, 1'b0);
    chk("done_pulse_high", done, 1'b1);
    chk("busy_low_at_done", busy, 1'b0);
    chk("rk_valid_low_at_done", rk_valid, 1'b0);
    // Counting the start cycle as cycle 1.
    if (ready_pct >= 100) chk("done_cycle", cyc + 1, 17);
    if (restart) begin
      start  = 1'b1;
      key_in = next_key;
    end
    step();
    start = 1'b0;
    chk("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] ka, kb, kb_in;
    reset    = 1'b1;
    start    = 1'b0;
    key_in   = '0;
    rk_ready = 1'b0;
    repeat (3) step();
    chk("reset_rk_valid", rk_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_rk_idx", rk_idx, 4'd0);
    chk("reset_rc", dut.rc, 8'h00);
    reset = 1'b0;
    step();

    run_stream(C3_KEY, 100, 1'b1, -1, -1, 1'b0, 1'b0, '0);
    chk("c3_k14", got_k[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
    chk("c3_k1",  got_k[1],  128'h101112131415161718191a1b1c1d1e1f);
    chk("c3_k0",  got_k[0],  128'h000102030405060708090a0b0c0d0e0f);

    run_stream(C3_KEY, 50, 1'b1, -1, -1, 1'b0, 1'b0, '0);
    chk("bp_k0", got_k[0], 128'h000102030405060708090a0b0c0d0e0f);

    for (int i = 0; i < 20; i++)
      run_stream(rand_key(), 100, 1'b0, -1, -1, 1'b0, 1'b0, '0);

    run_stream(rand_key(), 100, 1'b0, 5, -1, 1'b0, 1'b0, '0);

    run_stream(C3_KEY, 100, 1'b0, -1, 7, 1'b0, 1'b0, '0);
    run_stream(C3_KEY, 100, 1'b1, -1, -1, 1'b0, 1'b0, '0);

    ka = rand_key();
    kb = rand_key();
    expand_key(kb);
    kb_in = {mw[52], mw[53], mw[54], mw[55], mw[56], mw[57], mw[58], mw[59]};
    run_stream(ka, 100, 1'b0, -1, -1, 1'b0, 1'b1, kb_in);
    run_stream(kb, 100, 1'b0, -1, -1, 1'b1, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
